// File: rtl/extmem_parity.sv
// Byte-parity shim between bigmem's external memory port and the 18-bit memory:
// generates odd parity on writes, checks it on reads, logs errors for the ARM.
// CNT_W narrows the saturating error counter (default 16 bits; must be 1..16).
module extmem_parity #(
    parameter int RDLAT = 2,
    parameter int CNT_W = 16
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic [16:0] up_addr,
    input  logic [17:0] up_dout,
    output logic [17:0] up_din,
    input  logic        up_enab,
    input  logic [1:0]  up_wena,
    output logic [16:0] mem_addr,
    output logic [17:0] mem_dout,
    input  logic [17:0] mem_din,
    output logic        mem_enab,
    output logic [1:0]  mem_wena,
    output logic        parity_err_h
);

    localparam logic [31:0]      ID_WORD = 32'h4550_2001;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sticky, inj_h, inj_l, chk_en;
    logic [CNT_W-1:0] err_cnt, cnt_base, cnt_next;
    logic [15:0]      cnt16;
    logic [1:0]       fail_mask;
    logic [16:0]      fail_addr;
    logic             prev_rd, rd_now, launch;
    logic [RDLAT-1:0] pipe_v;
    logic [16:0]      pipe_a [RDLAT];
    logic             inj_h_use, inj_l_use, ph, pl;
    logic             bad_h, bad_l, err, wr1;

    assign mem_addr = up_addr;
    assign mem_enab = up_enab;
    assign mem_wena = up_wena;
    assign up_din   = mem_din;

    // Injection inverts the generated bit only on a cycle that actually writes that byte.
    assign inj_h_use = inj_h & up_enab & up_wena[1];
    assign inj_l_use = inj_l & up_enab & up_wena[0];
    assign ph        = ~^up_dout[16:9] ^ inj_h_use;
    assign pl        = ~^up_dout[7:0]  ^ inj_l_use;
    assign mem_dout  = {ph, up_dout[16:9], pl, up_dout[7:0]};

    // A held read enable is one access; only its first read cycle launches a check.
    assign rd_now = up_enab & ~|up_wena;
    assign launch = rd_now & ~prev_rd;

    assign bad_h        = ~^mem_din[17:9];
    assign bad_l        = ~^mem_din[8:0];
    assign err          = pipe_v[RDLAT-1] & chk_en & (bad_h | bad_l) & ~RESET;
    assign parity_err_h = err;

    assign wr1 = armwrite & (armwaddr == 2'd1);

    // Register clears are applied before the error update, so a same-cycle error survives.
    always_comb begin
        cnt_base = (wr1 & armwdata[27]) ? '0 : err_cnt;
        cnt_next = cnt_base;
        if (err && cnt_base != CNT_MAX)
            cnt_next = cnt_base + 1'b1;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sticky    <= 1'b0;
            inj_h     <= 1'b0;
            inj_l     <= 1'b0;
            chk_en    <= 1'b0;
            err_cnt   <= '0;
            fail_mask <= 2'b00;
            fail_addr <= 17'd0;
            prev_rd   <= 1'b0;
            pipe_v    <= '0;
        end else begin
            prev_rd   <= rd_now;
            pipe_v[0] <= launch;
            for (int i = 1; i < RDLAT; i++)
                pipe_v[i] <= pipe_v[i-1];
            inj_h   <= (wr1 ? armwdata[30] : inj_h) & ~inj_h_use;
            inj_l   <= (wr1 ? armwdata[29] : inj_l) & ~inj_l_use;
            chk_en  <= wr1 ? armwdata[28] : chk_en;
            sticky  <= (sticky & ~(wr1 & armwdata[31])) | err;
            err_cnt <= cnt_next;
            if (err) begin
                fail_mask <= {bad_h, bad_l};
                fail_addr <= pipe_a[RDLAT-1];
            end
        end
    end

    // Addresses need no reset: they are only used when the matching valid bit is set.
    always_ff @(posedge CLOCK) begin
        pipe_a[0] <= up_addr;
        for (int i = 1; i < RDLAT; i++)
            pipe_a[i] <= pipe_a[i-1];
    end

    assign cnt16 = 16'(err_cnt);

    always_comb begin
        armrdata = 32'd0;
        case (armraddr)
            2'd0:    armrdata = ID_WORD;
            2'd1:    armrdata = {sticky, inj_h, inj_l, chk_en, 12'd0, cnt16};
            2'd2:    armrdata = {fail_mask, 13'd0, fail_addr};
            default: armrdata = 32'd0;
        endcase
    end

endmodule
